// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_tx_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  // Serializer states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small circular-buffer FIFO with combinational head output.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A push into a full FIFO only lands when a pop frees a slot on the same edge
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, FIFO and serializer.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = 16'hFF00,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter logic [15:0] DEFAULT_DIV     = 16'd16
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [15:0] read_data,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  logic [15:0] offset;
  logic        wr_data, wr_status, wr_div;

  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  tx_state_e   state_q, state_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] div_act_q, div_act_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        bit_end;

  logic                     fifo_pop, fifo_full, fifo_empty;
  logic [7:0]               fifo_dout;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic [15:0]              status;

  // Modular subtraction keeps the window decode correct for any BASE_ADDR
  assign offset    = mem_address - BASE_ADDR;
  assign hit       = (offset < 16'd3);
  assign wr_data   = mem_write & hit & (offset[1:0] == OFF_DATA);
  assign wr_status = mem_write & hit & (offset[1:0] == OFF_STATUS);
  assign wr_div    = mem_write & hit & (offset[1:0] == OFF_DIV);
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign bit_end   = (cyc_q == div_act_q - 16'd1);

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (pc_reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (mem_write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STATUS word assembly and load-data mux
  always_comb begin
    status                     = '0;
    status[STAT_FULL]          = fifo_full;
    status[STAT_EMPTY]         = fifo_empty;
    status[STAT_BUSY]          = busy_q;
    status[STAT_OVF]           = ovf_q;
    status[STAT_CNT_LSB +: 3]  = 3'(fifo_count);
    read_data = '0;
    if (mem_read && hit) begin
      case (offset[1:0])
        OFF_STATUS: read_data = status;
        OFF_DIV:    read_data = div_q;
        default:    read_data = '0;
      endcase
    end
  end

  // Software-visible register updates
  always_comb begin
    div_d = div_q;
    if (wr_div) div_d = (mem_write_data == '0) ? 16'd1 : mem_write_data;
    ovf_d = ovf_q;
    if (wr_status && mem_write_data[STAT_OVF]) ovf_d = 1'b0;
    else if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Register file state
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  // Serializer state register
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Serializer next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_q == 3'd7) state_d = STOP;
      STOP:  if (bit_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Serializer datapath and FIFO pop per state
  always_comb begin
    tx_d      = tx_q;
    busy_d    = busy_q;
    cyc_d     = bit_end ? 16'd0 : cyc_q + 16'd1;
    div_act_d = div_act_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          div_act_d = div_q;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d  = shift_q[0];
          bit_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shift_q[1];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            div_act_d = div_q;
            tx_d      = 1'b0;
          end else begin
            busy_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Serializer datapath registers
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      cyc_q     <= '0;
      div_act_q <= DEFAULT_DIV;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      cyc_q     <= cyc_d;
      div_act_q <= div_act_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;

  logic        clk;
  logic        pc_reset;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] read_data;
  logic        hit;
  logic        tx;
  logic        busy;

  int unsigned n_checks;
  int unsigned n_errors;

  mmio_uart_tx #(
    .BASE_ADDR       (16'hFF00),
    .FIFO_DEPTH_LOG2 (2),
    .DEFAULT_DIV     (16'd16)
  ) dut (
    .clk            (clk),
    .pc_reset       (pc_reset),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .read_data      (read_data),
    .hit            (hit),
    .tx             (tx),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    mem_address    = addr;
    mem_write_data = data;
    mem_write      = 1'b1;
    tick();
    mem_write      = 1'b0;
    mem_address    = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data, output logic h);
    mem_address = addr;
    mem_read    = 1'b1;
    #1;
    data        = read_data;
    h           = hit;
    mem_read    = 1'b0;
    mem_address = 16'h0000;
  endtask

  // Check tx cycle-by-cycle for one 8N1 frame, starting c0 cycles after the pop edge
  task automatic check_frame(input logic [7:0] b, input int unsigned div, input int unsigned c0);
    int unsigned idx;
    logic        exp;
    for (int unsigned c = c0; c < 10 * div; c++) begin
      idx = c / div;
      if (idx == 0)      exp = 1'b0;
      else if (idx == 9) exp = 1'b1;
      else               exp = b[idx-1];
      check($sformatf("tx_%02h_c%0d", b, c), {31'd0, tx}, {31'd0, exp});
      tick();
    end
  endtask

  logic [15:0] rd;
  logic        h;

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    pc_reset       = 1'b1;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    repeat (3) tick();
    pc_reset = 1'b0;
    tick();

    // Reset state and address decode
    bus_read(16'hFF01, rd, h);
    check("rst_status", {16'd0, rd}, 32'h0002);
    check("rst_hit", {31'd0, h}, 32'd1);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    bus_read(16'hFF02, rd, h);
    check("rst_div", {16'd0, rd}, 32'd16);
    bus_read(16'hFF10, rd, h);
    check("miss_hit", {31'd0, h}, 32'd0);
    check("miss_rd", {16'd0, rd}, 32'd0);
    bus_read(16'hFF03, rd, h);
    check("ff03_hit", {31'd0, h}, 32'd0);
    bus_read(16'hFEFF, rd, h);
    check("feff_hit", {31'd0, h}, 32'd0);
    bus_read(16'hFF00, rd, h);
    check("data_rd0", {16'd0, rd}, 32'd0);
    check("data_hit", {31'd0, h}, 32'd1);

    // Single frame, DIV=4, byte A5
    bus_write(16'hFF02, 16'd4);
    bus_write(16'hFF00, 16'h00A5);
    bus_read(16'hFF01, rd, h);
    check("a5_status_k", {16'd0, rd}, 32'h0010);
    check("a5_tx_k", {31'd0, tx}, 32'd1);
    tick();
    bus_read(16'hFF01, rd, h);
    check("a5_status_k1", {16'd0, rd}, 32'h0006);
    check("a5_busy_start", {31'd0, busy}, 32'd1);
    check_frame(8'hA5, 4, 0);
    check("a5_busy_end", {31'd0, busy}, 32'd0);
    check("a5_tx_idle", {31'd0, tx}, 32'd1);

    // Five back-to-back frames, DIV=2, FIFO fills without overflow
    bus_write(16'hFF02, 16'd2);
    for (int unsigned i = 1; i <= 5; i++) bus_write(16'hFF00, 16'(i));
    bus_read(16'hFF01, rd, h);
    check("b2b_status_full", {16'd0, rd}, 32'h0045);
    check_frame(8'h01, 2, 3);
    for (int unsigned i = 2; i <= 5; i++) check_frame(8'(i), 2, 0);
    check("b2b_busy_end", {31'd0, busy}, 32'd0);
    bus_read(16'hFF01, rd, h);
    check("b2b_status_end", {16'd0, rd}, 32'h0002);

    // Divisor change mid-frame applies only from the next pop
    bus_write(16'hFF02, 16'd4);
    bus_write(16'hFF00, 16'h003C);
    bus_write(16'hFF00, 16'h00C3);
    bus_write(16'hFF02, 16'd8);
    bus_read(16'hFF02, rd, h);
    check("div_rd8", {16'd0, rd}, 32'd8);
    check_frame(8'h3C, 4, 1);
    check_frame(8'hC3, 8, 0);
    check("div_busy_end", {31'd0, busy}, 32'd0);
    bus_write(16'hFF02, 16'd0);
    bus_read(16'hFF02, rd, h);
    check("div_zero_rd1", {16'd0, rd}, 32'd1);

    // Overflow: six writes at DIV=100, then W1C
    bus_write(16'hFF02, 16'd100);
    for (int unsigned i = 0; i < 6; i++) bus_write(16'hFF00, 16'h0011 + 16'(i));
    bus_read(16'hFF01, rd, h);
    check("ovf_status", {16'd0, rd}, 32'h004D);
    bus_write(16'hFF01, 16'h0008);
    bus_read(16'hFF01, rd, h);
    check("ovf_cleared", {16'd0, rd}, 32'h0045);

    // Now 5 cycles past the pop of 0x11; move to cycle 250 (data bit 1 = 0)
    repeat (245) tick();
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset mid-frame
    pc_reset = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    pc_reset = 1'b0;
    tick();
    bus_read(16'hFF01, rd, h);
    check("post_rst_status", {16'd0, rd}, 32'h0002);
    bus_read(16'hFF02, rd, h);
    check("post_rst_div", {16'd0, rd}, 32'd16);
    repeat (20) tick();
    check("post_rst_tx_idle", {31'd0, tx}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
